// File: rtl/fp_multi_pipe.sv
// Four-stage pipelined binary floating-point multiplier with DAZ/FTZ handling,
// RNE/RTZ rounding and IEEE-style exception flags.
module fp_multi_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   rnd_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int EW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;

    localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO = EW'(0);
    localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} op_class_t;
    typedef enum logic [2:0] {SP_NONE, SP_QNAN, SP_INVALID, SP_INF, SP_ZERO} special_t;

    function automatic op_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0)
            return CLS_ZERO;
        else if (e == EXP_ONES)
            return (m == '0) ? CLS_INF : CLS_NAN;
        else
            return CLS_NORM;
    endfunction

    logic en;

    logic             s1_valid;
    logic             s1_sa;
    logic             s1_sb;
    logic [EXP_W-1:0] s1_ea;
    logic [EXP_W-1:0] s1_eb;
    logic [MAN_W-1:0] s1_ma;
    logic [MAN_W-1:0] s1_mb;
    logic             s1_rnd;
    op_class_t        s1_cls_a;
    op_class_t        s1_cls_b;

    logic                 s2_valid;
    logic                 s2_sign;
    logic signed [EW-1:0] s2_e;
    logic [PW-1:0]        s2_prod;
    logic                 s2_rnd;
    special_t             s2_special;

    logic                 s3_valid;
    logic                 s3_sign;
    logic signed [EW-1:0] s3_e;
    logic [MAN_W-1:0]     s3_man;
    logic                 s3_guard;
    logic                 s3_sticky;
    logic                 s3_rnd;
    special_t             s3_special;

    // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign busy     = s1_valid || s2_valid || s3_valid || out_valid;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sa    <= 1'b0;
            s1_sb    <= 1'b0;
            s1_ea    <= '0;
            s1_eb    <= '0;
            s1_ma    <= '0;
            s1_mb    <= '0;
            s1_rnd   <= 1'b0;
            s1_cls_a <= CLS_ZERO;
            s1_cls_b <= CLS_ZERO;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_sa    <= a[W-1];
            s1_sb    <= b[W-1];
            s1_ea    <= a[W-2 -: EXP_W];
            s1_eb    <= b[W-2 -: EXP_W];
            s1_ma    <= a[MAN_W-1:0];
            s1_mb    <= b[MAN_W-1:0];
            s1_rnd   <= rnd_mode;
            s1_cls_a <= classify(a[W-2 -: EXP_W], a[MAN_W-1:0]);
            s1_cls_b <= classify(b[W-2 -: EXP_W], b[MAN_W-1:0]);
        end
    end

    special_t             special_d;
    logic [PW-1:0]        ma_ext;
    logic [PW-1:0]        mb_ext;
    logic signed [EW-1:0] e_sum;

    // Special-operand resolution, highest priority first.
    always_comb begin
        special_d = SP_NONE;
        if (s1_cls_a == CLS_NAN || s1_cls_b == CLS_NAN)
            special_d = SP_QNAN;
        else if ((s1_cls_a == CLS_INF && s1_cls_b == CLS_ZERO) ||
                 (s1_cls_a == CLS_ZERO && s1_cls_b == CLS_INF))
            special_d = SP_INVALID;
        else if (s1_cls_a == CLS_INF || s1_cls_b == CLS_INF)
            special_d = SP_INF;
        else if (s1_cls_a == CLS_ZERO || s1_cls_b == CLS_ZERO)
            special_d = SP_ZERO;
    end

    assign ma_ext = {{(MAN_W+1){1'b0}}, 1'b1, s1_ma};
    assign mb_ext = {{(MAN_W+1){1'b0}}, 1'b1, s1_mb};
    assign e_sum  = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_e       <= '0;
            s2_prod    <= '0;
            s2_rnd     <= 1'b0;
            s2_special <= SP_NONE;
        end else if (en) begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sa ^ s1_sb;
            s2_e       <= e_sum;
            s2_prod    <= ma_ext * mb_ext;
            s2_rnd     <= s1_rnd;
            s2_special <= special_d;
        end
    end

    logic [PW-2:0]        prod_frac;
    logic signed [EW-1:0] e_norm;

    // Product of two [1,2) significands lies in [1,4): drop the leading one either way.
    always_comb begin
        if (s2_prod[PW-1]) begin
            prod_frac = s2_prod[PW-2:0];
            e_norm    = s2_e + E_ONE;
        end else begin
            prod_frac = {s2_prod[PW-3:0], 1'b0};
            e_norm    = s2_e;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid   <= 1'b0;
            s3_sign    <= 1'b0;
            s3_e       <= '0;
            s3_man     <= '0;
            s3_guard   <= 1'b0;
            s3_sticky  <= 1'b0;
            s3_rnd     <= 1'b0;
            s3_special <= SP_NONE;
        end else if (en) begin
            s3_valid   <= s2_valid;
            s3_sign    <= s2_sign;
            s3_e       <= e_norm;
            s3_man     <= prod_frac[PW-2 -: MAN_W];
            s3_guard   <= prod_frac[PW-2-MAN_W];
            s3_sticky  <= |prod_frac[PW-3-MAN_W:0];
            s3_rnd     <= s2_rnd;
            s3_special <= s2_special;
        end
    end

    logic                 round_up;
    logic                 man_carry;
    logic [MAN_W-1:0]     man_rnd;
    logic signed [EW-1:0] e_rnd;
    logic                 inexact;
    logic [W-1:0]         result_d;
    logic [3:0]           flags_d;

    assign round_up             = !s3_rnd && s3_guard && (s3_sticky || s3_man[0]);
    assign {man_carry, man_rnd} = {1'b0, s3_man} + {{MAN_W{1'b0}}, round_up};
    assign e_rnd                = man_carry ? s3_e + E_ONE : s3_e;
    assign inexact              = s3_guard || s3_sticky;

    // Final packing; range checks use the exponent after any rounding carry.
    always_comb begin
        result_d = {s3_sign, e_rnd[EXP_W-1:0], man_rnd};
        flags_d  = {3'b000, inexact};
        case (s3_special)
            SP_QNAN: begin
                result_d = QNAN;
                flags_d  = 4'b0000;
            end
            SP_INVALID: begin
                result_d = QNAN;
                flags_d  = 4'b1000;
            end
            SP_INF: begin
                result_d = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
                flags_d  = 4'b0000;
            end
            SP_ZERO: begin
                result_d = {s3_sign, {(W-1){1'b0}}};
                flags_d  = 4'b0000;
            end
            default: begin
                if (e_rnd >= E_MAX) begin
                    flags_d = 4'b0101;
                    if (s3_rnd)
                        result_d = {s3_sign, EXP_ONES - 1'b1, {MAN_W{1'b1}}};
                    else
                        result_d = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
                end else if (e_rnd <= E_ZERO) begin
                    result_d = {s3_sign, {(W-1){1'b0}}};
                    flags_d  = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (en) begin
            out_valid <= s3_valid;
            result    <= result_d;
            flags     <= flags_d;
        end
    end

endmodule
